// File: rtl/video_timing_pkg.sv
// Shared types for the video timing generator/detector pair: FSM states,
// the line/frame geometry record and a default 800x600 geometry.
package video_timing_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  localparam int TW = 16;

  typedef struct packed {
    logic [TW-1:0] htotal;
    logic [TW-1:0] hactive;
    logic [TW-1:0] vtotal;
    logic [TW-1:0] vactive;
  } timing_t;

  localparam int DEF_HTOTAL  = 1056;
  localparam int DEF_HACTIVE = 800;
  localparam int DEF_VTOTAL  = 628;
  localparam int DEF_VACTIVE = 600;

  localparam timing_t TIMING_800X600 = '{
    htotal:  TW'(DEF_HTOTAL),
    hactive: TW'(DEF_HACTIVE),
    vtotal:  TW'(DEF_VTOTAL),
    vactive: TW'(DEF_VACTIVE)
  };

endpackage

// File: rtl/sync_edge_detect.sv
// One-flop register of a synchronous input with combinational rise/fall
// pulses taken from the live input against the registered copy.
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic d_q, d_d;

  always_comb d_d = d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d_d;
  end

  assign q    = d_q;
  assign rise = d & ~d_q;
  assign fall = ~d & d_q;

endmodule

// File: rtl/video_timing_detector.sv
// Recovers active pixel coordinates from a DE/HSYNC/VSYNC stream, measures
// line/frame geometry and locks after LOCK_FRAMES consistent frames.
module video_timing_detector
  import video_timing_pkg::*;
#(
  parameter int HMAX        = 2048,
  parameter int VMAX        = 2048,
  parameter int LOCK_FRAMES = 2,
  parameter int HLEN        = $clog2(HMAX + 1),
  parameter int VLEN        = $clog2(VMAX + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_de,
  input  logic            i_hsync,
  input  logic            i_vsync,
  output logic            o_de,
  output logic [HLEN-1:0] o_hcount,
  output logic [VLEN-1:0] o_vcount,
  output logic            o_frame_start,
  output logic            o_locked,
  output logic [HLEN-1:0] o_htotal,
  output logic [HLEN-1:0] o_hactive,
  output logic [VLEN-1:0] o_vtotal,
  output logic [VLEN-1:0] o_vactive,
  output logic            o_err
);

  localparam int              MW    = $clog2(LOCK_FRAMES + 1);
  localparam logic [HLEN-1:0] HSAT  = HLEN'(HMAX);
  localparam logic [VLEN-1:0] VSAT  = VLEN'(VMAX);
  localparam logic [MW-1:0]   MLOCK = MW'(LOCK_FRAMES);

  function automatic logic [HLEN-1:0] hinc(input logic [HLEN-1:0] x);
    return (x == HSAT) ? x : x + HLEN'(1);
  endfunction

  function automatic logic [VLEN-1:0] vinc(input logic [VLEN-1:0] x);
    return (x == VSAT) ? x : x + VLEN'(1);
  endfunction

  logic de_q, de_rise, de_fall, hs_rise, vs_rise;
  logic unused_hs_q, unused_hs_fall, unused_vs_q, unused_vs_fall, unused_geom;

  sync_edge_detect u_de (.clk(clk), .rst(rst), .d(i_de),
                         .q(de_q), .rise(de_rise), .fall(de_fall));
  sync_edge_detect u_hs (.clk(clk), .rst(rst), .d(i_hsync),
                         .q(unused_hs_q), .rise(hs_rise), .fall(unused_hs_fall));
  sync_edge_detect u_vs (.clk(clk), .rst(rst), .d(i_vsync),
                         .q(unused_vs_q), .rise(vs_rise), .fall(unused_vs_fall));

  state_e          state_q, state_d;
  logic [MW-1:0]   match_q, match_d;
  logic [HLEN-1:0] hcount_q, hcount_d;
  logic [VLEN-1:0] vcount_q, vcount_d;
  logic [HLEN-1:0] h_cnt_q, h_cnt_d;
  logic            line_valid_q, line_valid_d;
  logic [HLEN-1:0] href_q, href_d;
  logic            href_valid_q, href_valid_d;
  logic [VLEN-1:0] v_cnt_q, v_cnt_d;
  logic [HLEN-1:0] de_len_q, de_len_d;
  logic            run_valid_q, run_valid_d;
  logic [HLEN-1:0] dref_q, dref_d;
  logic [VLEN-1:0] vact_q, vact_d;
  logic            frame_bad_q, frame_bad_d;
  timing_t         base_q, base_d;
  timing_t         geom_q, geom_d;
  logic            locked_q, locked_d;
  logic            err_q, err_d;
  logic            fstart_q, fstart_d;

  // Frame summary as it stands including this cycle's closing edges, so a
  // line or de run ending on the vsync edge still belongs to the old frame.
  logic            line_close, run_close, href_valid_eff, bad_eff, frame_ok, ovf;
  logic [HLEN-1:0] href_eff, dref_eff;
  logic [VLEN-1:0] vact_eff, vtot_eff;
  timing_t         frame;

  always_comb begin
    line_close     = hs_rise & line_valid_q;
    run_close      = de_fall & run_valid_q;
    href_eff       = (line_close && !href_valid_q) ? h_cnt_q : href_q;
    href_valid_eff = href_valid_q | line_close;
    dref_eff       = (run_close && vact_q == '0) ? de_len_q : dref_q;
    vact_eff       = run_close ? vinc(vact_q) : vact_q;
    vtot_eff       = hs_rise ? vinc(v_cnt_q) : v_cnt_q;
    bad_eff        = frame_bad_q
                   | (line_close & href_valid_q & (h_cnt_q != href_q))
                   | (run_close & (vact_q != '0) & (de_len_q != dref_q));
    frame          = '{htotal: TW'(href_eff), hactive: TW'(dref_eff),
                       vtotal: TW'(vtot_eff), vactive: TW'(vact_eff)};
    frame_ok       = !bad_eff && (vact_eff != '0) && href_valid_eff;
  end

  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    de_len_d = de_len_q;
    if (de_rise)   hcount_d = '0;
    else if (i_de) hcount_d = hinc(hcount_q);
    if (vs_rise)      vcount_d = '0;
    else if (de_fall) vcount_d = vinc(vcount_q);
    if (de_rise)   de_len_d = HLEN'(1);
    else if (i_de) de_len_d = hinc(de_len_q);

    if (vs_rise) begin
      h_cnt_d      = hs_rise ? HLEN'(1) : '0;
      line_valid_d = hs_rise;
      href_d       = '0;
      href_valid_d = 1'b0;
      v_cnt_d      = '0;
      dref_d       = '0;
      vact_d       = '0;
      frame_bad_d  = 1'b0;
      run_valid_d  = de_rise;
    end else begin
      h_cnt_d      = hs_rise ? HLEN'(1) : hinc(h_cnt_q);
      line_valid_d = line_valid_q | hs_rise;
      href_d       = href_eff;
      href_valid_d = href_valid_eff;
      v_cnt_d      = vtot_eff;
      dref_d       = dref_eff;
      vact_d       = vact_eff;
      frame_bad_d  = bad_eff;
      run_valid_d  = run_valid_q | de_rise;
    end

    ovf = ((h_cnt_d == HSAT) && (h_cnt_q != HSAT)) ||
          ((v_cnt_d == VSAT) && (v_cnt_q != VSAT));
  end

  // state   | meaning
  // SEARCH  | waiting for a vsync edge to start measuring
  // MEASURE | counting consecutive matching frames toward lock
  // LOCKED  | geometry valid; each frame checked against the baseline
  always_comb begin
    state_d  = state_q;
    match_d  = match_q;
    base_d   = base_q;
    geom_d   = geom_q;
    err_d    = 1'b0;
    fstart_d = vs_rise;

    case (state_q)
      SEARCH: begin
        if (vs_rise) begin
          state_d = MEASURE;
          match_d = '0;
        end
      end
      MEASURE: begin
        if (vs_rise) begin
          if (!frame_ok) begin
            match_d = '0;
          end else begin
            base_d  = frame;
            match_d = (match_q == '0 || frame == base_q) ? match_q + MW'(1) : MW'(1);
            if (match_d == MLOCK) begin
              state_d = LOCKED;
              geom_d  = frame;
            end
          end
        end
      end
      LOCKED: begin
        if (vs_rise && (!frame_ok || frame != base_q)) begin
          err_d   = 1'b1;
          state_d = MEASURE;
          match_d = '0;
        end
      end
      default: state_d = SEARCH;
    endcase

    if (ovf) begin
      err_d   = 1'b1;
      state_d = SEARCH;
      match_d = '0;
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= SEARCH;
      match_q      <= '0;
      hcount_q     <= '0;
      vcount_q     <= '0;
      h_cnt_q      <= '0;
      line_valid_q <= 1'b0;
      href_q       <= '0;
      href_valid_q <= 1'b0;
      v_cnt_q      <= '0;
      de_len_q     <= '0;
      run_valid_q  <= 1'b0;
      dref_q       <= '0;
      vact_q       <= '0;
      frame_bad_q  <= 1'b0;
      base_q       <= '0;
      geom_q       <= '0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
      fstart_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      match_q      <= match_d;
      hcount_q     <= hcount_d;
      vcount_q     <= vcount_d;
      h_cnt_q      <= h_cnt_d;
      line_valid_q <= line_valid_d;
      href_q       <= href_d;
      href_valid_q <= href_valid_d;
      v_cnt_q      <= v_cnt_d;
      de_len_q     <= de_len_d;
      run_valid_q  <= run_valid_d;
      dref_q       <= dref_d;
      vact_q       <= vact_d;
      frame_bad_q  <= frame_bad_d;
      base_q       <= base_d;
      geom_q       <= geom_d;
      locked_q     <= locked_d;
      err_q        <= err_d;
      fstart_q     <= fstart_d;
    end
  end

  assign o_de          = de_q;
  assign o_hcount      = hcount_q;
  assign o_vcount      = vcount_q;
  assign o_frame_start = fstart_q;
  assign o_locked      = locked_q;
  assign o_err         = err_q;
  assign o_htotal      = geom_q.htotal[HLEN-1:0];
  assign o_hactive     = geom_q.hactive[HLEN-1:0];
  assign o_vtotal      = geom_q.vtotal[VLEN-1:0];
  assign o_vactive     = geom_q.vactive[VLEN-1:0];
  assign unused_geom   = ^geom_q;

endmodule
